// File: rtl/cam_capture_rgb444_pkg.sv
// ---------------------------------------------------------------------------
// cam_capture_rgb444_pkg
// Shared definitions for the OV7670-style RGB444 capture stage:
//   - capture FSM state encoding
//   - RGB444 field positions inside the 12-bit pixel word
//   - default active-window geometry
//   - pixel packing helpers (camera path and test pattern)
// The test-pattern path is selected in the top by `CAM_CAPTURE_TESTPAT_EN.
// ---------------------------------------------------------------------------
package cam_capture_rgb444_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_VS   = 2'd1,
        ST_ACTIVE    = 2'd2,
        ST_FRAME_END = 2'd3
    } cap_state_e;

    localparam int RGB_W = 12;
    localparam int R_HI  = 11;
    localparam int R_LO  = 8;
    localparam int G_HI  = 7;
    localparam int G_LO  = 4;
    localparam int B_HI  = 3;
    localparam int B_LO  = 0;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;

    typedef logic [RGB_W-1:0] rgb444_t;

    function automatic rgb444_t pack_rgb(input logic [3:0] r,
                                         input logic [3:0] g,
                                         input logic [3:0] b);
        rgb444_t p;
        p = '0;
        p[R_HI:R_LO] = r;
        p[G_HI:G_LO] = g;
        p[B_HI:B_LO] = b;
        return p;
    endfunction

    // Position-derived pattern: R=x[7:4], G=y[7:4], B=x[3:0]^y[3:0].
    function automatic rgb444_t test_pattern(input logic [7:0] x,
                                             input logic [7:0] y);
        return pack_rgb(x[7:4], y[7:4], x[3:0] ^ y[3:0]);
    endfunction

endpackage

// File: rtl/cam_capture_rgb444_if.sv
// ---------------------------------------------------------------------------
// cam_capture_rgb444_if
// Bundles the camera byte-stream inputs and the pixel-stream outputs of the
// capture stage.
//   i_enable      arm capture (looked at on frame boundaries only)
//   i_cam_vsync   camera VSYNC
//   i_cam_href    camera HREF, high during the active bytes of a line
//   i_cam_data    camera data byte
//   o_data        pixel {R,G,B} 4 bits each, 0 when o_valid=0
//   o_valid       one-cycle strobe per pixel
//   o_sof/o_eol   first pixel of frame / last pixel of line markers
//   o_frame_done  pulse after a complete, well-formed frame
//   o_err         sticky malformed-frame flag
// Modports: master = camera/source side, slave = capture block.
// ---------------------------------------------------------------------------
interface cam_capture_rgb444_if;
    import cam_capture_rgb444_pkg::*;

    logic       i_enable;
    logic       i_cam_vsync;
    logic       i_cam_href;
    logic [7:0] i_cam_data;
    rgb444_t    o_data;
    logic       o_valid;
    logic       o_sof;
    logic       o_eol;
    logic       o_frame_done;
    logic       o_err;

    modport master (
        output i_enable, i_cam_vsync, i_cam_href, i_cam_data,
        input  o_data, o_valid, o_sof, o_eol, o_frame_done, o_err
    );

    modport slave (
        input  i_enable, i_cam_vsync, i_cam_href, i_cam_data,
        output o_data, o_valid, o_sof, o_eol, o_frame_done, o_err
    );

endinterface

// File: rtl/cam_capture_rgb444_sync.sv
// ---------------------------------------------------------------------------
// cam_sync_edge
// Registers a camera timing signal and reports its edges relative to the
// previous sample.
//   clk   pixel clock
//   rst   async active-high reset (previous value resets to 0)
//   d     current level
//   rise  d=1 now, 0 on the previous clock
//   fall  d=0 now, 1 on the previous clock
// ---------------------------------------------------------------------------
module cam_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 1'b0;
        else     q <= d;
    end

    assign rise = d & ~q;
    assign fall = ~d & q;

endmodule

// File: rtl/cam_capture_rgb444.sv
// ---------------------------------------------------------------------------
// cam_capture_rgb444
// Camera-side capture: assembles OV7670 RGB444 byte pairs into 12-bit pixels,
// tracks x/y inside the active window, and flags malformed frames.
//   i_clk  camera pixel clock (rising edge)
//   i_rst  asynchronous active-high reset; release is expected to be
//          synchronous to i_clk
//   bus    cam_capture_rgb444_if.slave (camera inputs, pixel outputs)
// Parameters: H_ACTIVE, V_ACTIVE (window size), VSYNC_POL (VSYNC active level).
// Build option: define CAM_CAPTURE_TESTPAT_EN to replace camera data with a
// position-derived test pattern; timing/valid/sof/eol are unchanged.
// ---------------------------------------------------------------------------
module cam_capture_rgb444
    import cam_capture_rgb444_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter bit VSYNC_POL = 1'b1
) (
    input logic             i_clk,
    input logic             i_rst,
    cam_capture_rgb444_if.slave bus
);
    // Counters hold one past the window so they can saturate at H/V_ACTIVE:
    // "counter == max" then means "outside the window".
    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam logic [XW-1:0] X_MAX  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(V_ACTIVE);

    cap_state_e    state_q, state_d;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          phase;
    logic          in_line;
    logic          frame_err;
    rgb444_t       pix;

    logic vs_act;
    logic vs_rise, vs_fall, href_rise, href_fall;

    assign vs_act = (bus.i_cam_vsync == VSYNC_POL);

    cam_sync_edge u_vs_edge (
        .clk  (i_clk),
        .rst  (i_rst),
        .d    (vs_act),
        .rise (vs_rise),
        .fall (vs_fall)
    );

    cam_sync_edge u_href_edge (
        .clk  (i_clk),
        .rst  (i_rst),
        .d    (bus.i_cam_href),
        .rise (href_rise),
        .fall (href_fall)
    );

    // ---------------- FSM ----------------
    logic frame_start;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        unique case (state_q)
            ST_IDLE:      if (bus.i_enable) state_d = ST_WAIT_VS;
            ST_WAIT_VS:   if (vs_fall) begin
                              state_d     = ST_ACTIVE;
                              frame_start = 1'b1;
                          end
            ST_ACTIVE:    if (vs_rise) state_d = ST_FRAME_END;
            ST_FRAME_END: state_d = bus.i_enable ? ST_WAIT_VS : ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // ---------------- pixel source ----------------
`ifdef CAM_CAPTURE_TESTPAT_EN
    logic unused_cam_data;
    assign unused_cam_data = ^bus.i_cam_data;
    assign pix = test_pattern(8'(x), 8'(y));
`else
    logic [3:0] r_lat;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_lat <= 4'h0;
        else if (state_q == ST_ACTIVE && bus.i_cam_href && !phase)
            r_lat <= bus.i_cam_data[3:0];
    end

    assign pix = pack_rgb(r_lat, bus.i_cam_data[7:4], bus.i_cam_data[3:0]);
`endif

    // ---------------- capture datapath ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            x                <= '0;
            y                <= '0;
            phase            <= 1'b0;
            in_line          <= 1'b0;
            frame_err        <= 1'b0;
            bus.o_data       <= '0;
            bus.o_valid      <= 1'b0;
            bus.o_sof        <= 1'b0;
            bus.o_eol        <= 1'b0;
            bus.o_frame_done <= 1'b0;
            bus.o_err        <= 1'b0;
        end else begin
            bus.o_data       <= '0;
            bus.o_valid      <= 1'b0;
            bus.o_sof        <= 1'b0;
            bus.o_eol        <= 1'b0;
            bus.o_frame_done <= 1'b0;

            if (frame_start) begin
                x         <= '0;
                y         <= '0;
                phase     <= 1'b0;
                in_line   <= 1'b0;
                frame_err <= 1'b0;
            end else if (state_q == ST_ACTIVE) begin
                if (vs_rise) begin
                    // Frame closes here; anything short of V_ACTIVE lines is truncated.
                    in_line <= 1'b0;
                    if (y != Y_MAX) begin
                        frame_err <= 1'b1;
                        bus.o_err <= 1'b1;
                    end
                end else if (href_fall) begin
                    if (in_line) begin
                        // Odd byte count or short line; long lines saturate at X_MAX.
                        if (phase || x != X_MAX) begin
                            frame_err <= 1'b1;
                            bus.o_err <= 1'b1;
                        end
                        if (x != '0 && y != Y_MAX) y <= y + 1'b1;
                    end
                    x       <= '0;
                    phase   <= 1'b0;
                    in_line <= 1'b0;
                end else if (bus.i_cam_href && (in_line || href_rise)) begin
                    // Only lines whose HREF rose inside ACTIVE are captured, so a
                    // line already in flight when the frame opened is skipped.
                    in_line <= 1'b1;
                    phase   <= ~phase;
                    if (phase && x != X_MAX) begin
                        x <= x + 1'b1;
                        if (y != Y_MAX) begin
                            bus.o_valid <= 1'b1;
                            bus.o_data  <= pix;
                            bus.o_sof   <= (x == '0) && (y == '0);
                            bus.o_eol   <= (x == X_LAST);
                        end
                    end
                end
            end

            if (state_q == ST_FRAME_END && y == Y_MAX && !frame_err)
                bus.o_frame_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cam_capture_rgb444.sv
// ---------------------------------------------------------------------------
// tb_cam_capture_rgb444
// Drives byte-level camera frames (fixed and $urandom data / line lengths)
// into cam_capture_rgb444 with a 4x2 window and compares the pixel stream,
// frame_done pulses and error flag against a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_cam_capture_rgb444;
    import cam_capture_rgb444_pkg::*;

    localparam int H = 4;
    localparam int V = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cam_capture_rgb444_if bus ();

    cam_capture_rgb444 #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (V),
        .VSYNC_POL (1'b1)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [13:0] obs_q[$];
    logic [13:0] exp_q[$];
    int          done_cnt = 0;
    int          idle_bad = 0;
    bit          armed = 1'b0;   // model: next frame will be captured
    bit          err_m = 1'b0;   // model: sticky error
    int          lens[$];
    logic [7:0]  bytes_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled away from the rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_valid) obs_q.push_back({bus.o_data, bus.o_sof, bus.o_eol});
            else if (bus.o_data !== 12'h0 || bus.o_sof || bus.o_eol) idle_bad++;
            if (bus.o_frame_done) done_cnt++;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic vs_pulse();
        for (int i = 0; i < 3; i++) begin @(negedge clk); bus.i_cam_vsync = 1'b1; end
        for (int i = 0; i < 3; i++) begin @(negedge clk); bus.i_cam_vsync = 1'b0; end
    endtask

    // Frame-level reference: pixels per line = bytes/2, window clipping,
    // line/frame well-formedness rules.
    task automatic model(output int done_e);
        int  y, off, np;
        bit  ferr;
        logic [7:0] b0, b1;
        logic [11:0] e;
        y = 0; off = 0; ferr = 1'b0; done_e = 0;
        exp_q = {};
        if (!armed) return;
        foreach (lens[i]) begin
            np = lens[i] / 2;
            for (int p = 0; p < np; p++) begin
                if (p < H && y < V) begin
                    b0 = bytes_q[off + 2*p];
                    b1 = bytes_q[off + 2*p + 1];
`ifdef CAM_CAPTURE_TESTPAT_EN
                    e = {4'(p >> 4), 4'(y >> 4), 4'(p) ^ 4'(y)};
`else
                    e = {b0[3:0], b1};
`endif
                    exp_q.push_back({e, (p == 0 && y == 0), (p == H-1)});
                end
            end
            if ((lens[i] % 2) != 0 || np < H) ferr = 1'b1;
            if (np > 0 && y < V) y++;
            off += lens[i];
        end
        if (y != V) ferr = 1'b1;
        if (ferr) err_m = 1'b1;
        done_e = ferr ? 0 : 1;
    endtask

    // Drive the lines in `lens`, close the frame with a VSYNC pulse, check it.
    task automatic send_frame(input bit fixed, input string tag);
        int done_e;
        logic [7:0] d;
        obs_q = {}; bytes_q = {}; done_cnt = 0; idle_bad = 0;
        foreach (lens[i]) begin
            for (int k = 0; k < lens[i]; k++) begin
                d = fixed ? (((k % 2) == 0) ? 8'h0A : 8'h5C) : 8'($urandom);
                @(negedge clk);
                bus.i_cam_href = 1'b1;
                bus.i_cam_data = d;
                bytes_q.push_back(d);
            end
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                bus.i_cam_href = 1'b0;
                bus.i_cam_data = 8'($urandom);
            end
        end
        vs_pulse();
        model(done_e);
        chk({tag, "_npix"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("%s_pix%0d", tag, i), obs_q[i], exp_q[i]);
        chk({tag, "_done"}, done_cnt, done_e);
        chk({tag, "_err"}, bus.o_err, err_m);
        chk({tag, "_idle_data"}, idle_bad, 0);
        armed = bus.i_enable;
    endtask

    initial begin
        int tbl[9];
        int nl;
        tbl = '{8, 8, 8, 8, 7, 12, 6, 2, 3};
        bus.i_enable = 1'b0; bus.i_cam_vsync = 1'b0;
        bus.i_cam_href = 1'b0; bus.i_cam_data = 8'h00;

        tick(3);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_data", bus.o_data, 0);
        chk("rst_sof", bus.o_sof, 0);
        chk("rst_eol", bus.o_eol, 0);
        chk("rst_done", bus.o_frame_done, 0);
        chk("rst_err", bus.o_err, 0);
        @(negedge clk); rst = 1'b0;

        bus.i_enable = 1'b1;
        tick(3);
        vs_pulse();
        armed = 1'b1;

        lens = {8, 8};  send_frame(1'b1, "fix0");
        lens = {8, 8};  send_frame(1'b1, "fix1");
        lens = {7, 8};  send_frame(1'b0, "odd");
        lens = {12, 8}; send_frame(1'b0, "long");
        lens = {8};     send_frame(1'b0, "trunc");
        lens = {8, 8};  send_frame(1'b0, "after_trunc");

        for (int f = 0; f < 8; f++) begin
            nl = $urandom_range(1, 3);
            lens = {};
            for (int l = 0; l < nl; l++) lens.push_back(tbl[$urandom_range(0, 8)]);
            send_frame(1'b0, $sformatf("rnd%0d", f));
        end

        bus.i_enable = 1'b0;
        lens = {8, 8}; send_frame(1'b0, "en_drop");
        lens = {8, 8}; send_frame(1'b0, "idle0");
        lens = {8, 8}; send_frame(1'b0, "idle1");
        bus.i_enable = 1'b1;
        lens = {8, 8}; send_frame(1'b0, "rearm");

        // Reset in the middle of a line, right after a pixel came out.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.i_cam_href = 1'b1;
            bus.i_cam_data = ((k % 2) == 0) ? 8'h0A : 8'h5C;
        end
        @(negedge clk);
        chk("pre_rst_valid", bus.o_valid, 1);
        chk("pre_rst_data", bus.o_data, 12'hA5C);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", bus.o_valid, 0);
        chk("async_rst_data", bus.o_data, 0);
        chk("async_rst_err", bus.o_err, 0);
        tick(2);
        bus.i_cam_href = 1'b0;
        rst = 1'b0;
        armed = 1'b0;
        err_m = 1'b0;
        lens = {8, 8}; send_frame(1'b0, "post_rst");
        lens = {8, 8}; send_frame(1'b0, "post_rst_cap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
